// File: rtl/uart_frame_loader.sv
// uart_frame_loader: parses framed, checksummed load packets from a UART byte stream,
// streams each assembled word into a memory write port, and holds the core in soft reset
// until a frame passes its checksum.
// Frame: SYNC | ADDR (AB bytes LE) | COUNT (2 bytes LE) | COUNT*DB payload bytes | CHK
module uart_frame_loader #(
    parameter int          DATA_WIDTH        = 32,
    parameter int          ADDR_WIDTH        = 11,
    parameter logic [7:0]  SYNC_BYTE         = 8'hA5,
    parameter int          RESET_HOLD_CYCLES = 16,
    parameter int          TIMEOUT_CYCLES    = 1000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            uart_receiver_data,
    input  logic                  uart_receiver_data_ready,
    output logic                  system_soft_reset,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write_req,
    output logic                  busy,
    output logic                  error
);

    localparam int DB   = DATA_WIDTH / 8;
    localparam int AB   = (ADDR_WIDTH + 7) / 8;
    localparam int MAXB = (AB > DB) ? ((AB > 2) ? AB : 2) : ((DB > 2) ? DB : 2);
    localparam int CW   = $clog2(MAXB);
    localparam int TW   = $clog2(TIMEOUT_CYCLES);
    localparam int HW   = $clog2(RESET_HOLD_CYCLES + 1);

    localparam logic [CW-1:0] C_LAST_AB = CW'(AB - 1);
    localparam logic [CW-1:0] C_LAST_DB = CW'(DB - 1);
    localparam logic [TW-1:0] C_TMO_END = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] C_HLD_END = HW'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_COUNT = 3'd2,
        S_DATA  = 3'd3,
        S_CHECK = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_byte_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_count_lo;
    logic [15:0]           r_words_left;
    logic [DATA_WIDTH-1:0] r_word;
    logic [7:0]            r_chk;
    logic [TW-1:0]         r_idle_cnt;
    logic [HW-1:0]         r_hold_cnt;
    logic                  r_soft_reset;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_wr_req;
    logic                  r_busy;
    logic                  r_error;

    logic                  w_sync_start;
    logic [7:0]            w_chk_sum;
    logic [15:0]           w_count_full;
    logic [DATA_WIDTH-1:0] w_word;

    // A SYNC byte opens a new frame from IDLE, and also restarts from HOLD
    assign w_sync_start = uart_receiver_data_ready && (uart_receiver_data == SYNC_BYTE) &&
                          ((r_state == S_IDLE) || (r_state == S_HOLD));
    assign w_chk_sum    = r_chk + uart_receiver_data;
    assign w_count_full = {uart_receiver_data, r_count_lo};

    // Current word with the incoming byte dropped into its little-endian lane
    always_comb begin
        w_word = r_word;
        w_word[{r_byte_cnt, 3'b000} +: 8] = uart_receiver_data;
    end

    // Frame parser: state, counters, checksum and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_byte_cnt   <= '0;
            r_addr       <= '0;
            r_count_lo   <= '0;
            r_words_left <= '0;
            r_word       <= '0;
            r_chk        <= '0;
            r_idle_cnt   <= '0;
            r_hold_cnt   <= '0;
            r_soft_reset <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_req     <= 1'b0;
            r_busy       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_wr_req <= 1'b0;
            if (w_sync_start) begin
                r_state      <= S_ADDR;
                r_byte_cnt   <= '0;
                r_chk        <= '0;
                r_idle_cnt   <= '0;
                r_error      <= 1'b0;
                r_soft_reset <= 1'b1;
                r_busy       <= 1'b1;
            end else begin
                case (r_state)
                    S_ADDR, S_COUNT, S_DATA, S_CHECK: begin
                        if (uart_receiver_data_ready) begin
                            r_idle_cnt <= '0;
                            r_chk      <= w_chk_sum;
                            case (r_state)
                                S_ADDR: begin
                                    // Header bytes above ADDR_WIDTH are simply dropped
                                    for (int i = 0; i < ADDR_WIDTH; i++) begin
                                        if (i / 8 == int'(r_byte_cnt))
                                            r_addr[i] <= uart_receiver_data[i % 8];
                                    end
                                    if (r_byte_cnt == C_LAST_AB) begin
                                        r_byte_cnt <= '0;
                                        r_state    <= S_COUNT;
                                    end else begin
                                        r_byte_cnt <= r_byte_cnt + 1'b1;
                                    end
                                end
                                S_COUNT: begin
                                    if (r_byte_cnt == '0) begin
                                        r_count_lo <= uart_receiver_data;
                                        r_byte_cnt <= r_byte_cnt + 1'b1;
                                    end else begin
                                        r_byte_cnt   <= '0;
                                        r_words_left <= w_count_full;
                                        r_state      <= (w_count_full == 16'd0) ? S_CHECK : S_DATA;
                                    end
                                end
                                S_DATA: begin
                                    r_word <= w_word;
                                    if (r_byte_cnt == C_LAST_DB) begin
                                        r_byte_cnt   <= '0;
                                        r_wr_req     <= 1'b1;
                                        r_wr_addr    <= r_addr;
                                        r_wr_data    <= w_word;
                                        r_addr       <= r_addr + 1'b1;
                                        r_words_left <= r_words_left - 1'b1;
                                        if (r_words_left == 16'd1)
                                            r_state <= S_CHECK;
                                    end else begin
                                        r_byte_cnt <= r_byte_cnt + 1'b1;
                                    end
                                end
                                default: begin
                                    // CHECK: a bad image keeps the core in reset
                                    if (w_chk_sum == 8'h00) begin
                                        r_state    <= S_HOLD;
                                        r_hold_cnt <= '0;
                                    end else begin
                                        r_error <= 1'b1;
                                        r_state <= S_IDLE;
                                        r_busy  <= 1'b0;
                                    end
                                end
                            endcase
                        end else if (r_idle_cnt == C_TMO_END) begin
                            r_error <= 1'b1;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (r_hold_cnt == C_HLD_END) begin
                            r_soft_reset <= 1'b0;
                            r_state      <= S_IDLE;
                            r_busy       <= 1'b0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign system_soft_reset = r_soft_reset;
    assign mem_write_addr    = r_wr_addr;
    assign mem_write_data    = r_wr_data;
    assign mem_write_req     = r_wr_req;
    assign busy              = r_busy;
    assign error             = r_error;

endmodule

// File: tb/tb_uart_frame_loader.sv
// tb_uart_frame_loader: directed frames against a byte-level frame model; expected writes
// are queued from the frame contents and checked every cycle a write strobe appears.
module tb_uart_frame_loader;

    localparam int DW   = 32;
    localparam int AW   = 11;
    localparam int HOLD = 16;
    localparam int TMO  = 40;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_rdy = 1'b0;
    logic          soft_rst;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_req;
    logic          busy;
    logic          error;

    int total = 0;
    int bad   = 0;

    logic [AW+DW-1:0] exp_wr[$];
    logic [7:0]       fb[$];
    logic [DW-1:0]    words[8];
    logic [7:0]       lit1[10] = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h00,
                                   8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB7};

    uart_frame_loader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5),
        .RESET_HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .uart_receiver_data      (rx_data),
        .uart_receiver_data_ready(rx_rdy),
        .system_soft_reset       (soft_rst),
        .mem_write_addr          (wr_addr),
        .mem_write_data          (wr_data),
        .mem_write_req           (wr_req),
        .busy                    (busy),
        .error                   (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every write strobe must match the oldest write the frame model predicted
    always @(negedge clk) begin
        if (reset_n && wr_req) begin
            if (exp_wr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h expected none", wr_addr, wr_data);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_wr.pop_front();
                chk("write", {wr_addr, wr_data}, e);
                $display("write addr=%03h data=%08h", wr_addr, wr_data);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One byte strobe; returns at the negedge just after the DUT sampled it
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(negedge clk);
        rx_rdy  = 1'b0;
    endtask

    // Frame model: SYNC, 2 address bytes, 2 count bytes, words LE, then the negated sum
    task automatic build_frame(input logic [15:0] raw_addr, input int n, input logic [7:0] bump);
        logic [7:0] s;
        s = 8'h00;
        fb.delete();
        fb.push_back(8'hA5);
        fb.push_back(raw_addr[7:0]);
        fb.push_back(raw_addr[15:8]);
        fb.push_back(8'(n));
        fb.push_back(8'(n >> 8));
        for (int w = 0; w < n; w++)
            for (int b = 0; b < 4; b++)
                fb.push_back(8'(words[w] >> (8 * b)));
        for (int i = 1; i < fb.size(); i++) s = s + fb[i];
        fb.push_back(8'h00 - s + bump);
    endtask

    // Sends the first 'limit' bytes of a frame (all when limit<0) with per-byte checks
    task automatic send_frame(input logic [15:0] raw_addr, input int n, input logic [7:0] bump,
                              input int limit);
        int nsent;
        logic [AW-1:0] a;
        build_frame(raw_addr, n, bump);
        nsent = (limit < 0) ? fb.size() : limit;
        for (int w = 0; w < n; w++) begin
            if (5 + 4 * w + 3 < nsent) begin
                a = raw_addr[AW-1:0] + AW'(w);
                exp_wr.push_back({a, words[w]});
            end
        end
        for (int i = 0; i < nsent; i++) begin
            send_byte(fb[i]);
            chk("req_timing", wr_req, (i >= 5 && i < 5 + 4 * n && (i - 5) % 4 == 3));
            chk("soft_reset_in_frame", soft_rst, 1'b1);
            if (i < fb.size() - 1) begin
                chk("busy_in_frame", busy, 1'b1);
                chk("error_in_frame", error, 1'b0);
                idle(2);
            end else begin
                chk("busy_after_chk", busy, bump == 8'h00);
                chk("error_after_chk", error, bump != 8'h00);
            end
        end
        $display("frame addr=%04h words=%0d bump=%0h sent=%0d", raw_addr, n, bump, nsent);
    endtask

    task automatic wait_srst_fall(input string name);
        int k;
        k = 0;
        while (soft_rst === 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(name, k, HOLD);
        chk("busy_after_hold", busy, 1'b0);
        chk("error_after_hold", error, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        // Reset state
        idle(3);
        chk("rst_soft_reset", soft_rst, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_req", wr_req, 1'b0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        reset_n = 1'b1;
        idle(2);

        // Non-SYNC bytes in IDLE are ignored
        send_byte(8'h00);
        idle(1);
        send_byte(8'h11);
        idle(2);
        chk("idle_busy", busy, 1'b0);
        chk("idle_soft_reset", soft_rst, 1'b0);
        chk("idle_error", error, 1'b0);

        // Test 1: the model must reproduce the hand-written frame exactly
        words[0] = 32'hDEADBEEF;
        build_frame(16'h0010, 1, 8'h00);
        chk("model_len", fb.size(), 10);
        for (int i = 0; i < 10; i++) chk("model_byte", fb[i], lit1[i]);
        send_frame(16'h0010, 1, 8'h00, -1);
        chk("t1_addr_lit", wr_addr, 11'h010);
        chk("t1_data_lit", wr_data, 32'hDEADBEEF);
        wait_srst_fall("t1_hold_len");

        // Test 2: bad checksum, then a good frame clears error and soft reset
        send_frame(16'h0010, 1, 8'h01, -1);
        chk("t2_chk_lit", fb[9], 8'hB8);
        idle(20);
        chk("t2_error", error, 1'b1);
        chk("t2_soft_reset", soft_rst, 1'b1);
        chk("t2_busy", busy, 1'b0);
        words[0] = 32'h01234567;
        send_frame(16'h0123, 1, 8'h00, -1);
        wait_srst_fall("t2_hold_len");

        // Test 3: address wrap from 0x7FF to 0x000
        words[0] = 32'h11223344;
        words[1] = 32'hAABBCCDD;
        build_frame(16'h07FF, 2, 8'h00);
        chk("t3_chk_lit", fb[13], 8'h40);
        send_frame(16'h07FF, 2, 8'h00, -1);
        chk("t3_last_addr", wr_addr, 11'h000);
        chk("t3_last_data", wr_data, 32'hAABBCCDD);
        idle(3);

        // Test 4: zero-count frame started by SYNC during HOLD
        send_frame(16'h0000, 0, 8'h00, -1);
        chk("t4_chk_lit", fb[5], 8'h00);
        wait_srst_fall("t4_hold_len");

        // Test 5: inter-byte timeout
        send_byte(8'hA5);
        idle(2);
        send_byte(8'h10);
        k = 0;
        while (error !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t5_timeout_len", k, TMO);
        chk("t5_busy", busy, 1'b0);
        chk("t5_soft_reset", soft_rst, 1'b1);

        // Test 6: reset mid-payload, then a frame with high address bits set
        words[0] = 32'hCAFEF00D;
        words[1] = 32'h12345678;
        send_frame(16'h0200, 2, 8'h00, 11);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t6_soft_reset", soft_rst, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_error", error, 1'b0);
        chk("t6_req", wr_req, 1'b0);
        chk("t6_addr", wr_addr, 0);
        chk("t6_data", wr_data, 0);
        idle(2);
        reset_n = 1'b1;
        idle(2);
        words[0] = 32'h0BADC0DE;
        send_frame(16'hFC05, 1, 8'h00, -1);
        chk("t6_masked_addr", wr_addr, 11'h405);
        wait_srst_fall("t6_hold_len");

        idle(4);
        chk("pending_writes", exp_wr.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
